// File: rtl/regfile_scoreboard_if.sv
// Decode/writeback port bundle of the register file: two read ports with busy flags,
// one write port, the reservation handshake, flush and the busy count.
interface regfile_scoreboard_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    logic [AW-1:0]   rs1_addr;
    logic [AW-1:0]   rs2_addr;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            rs1_busy;
    logic            rs2_busy;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [XLEN-1:0] wr_data;
    logic            rsv_en;
    logic [AW-1:0]   rsv_addr;
    logic            rsv_ok;
    logic            flush;
    logic [AW:0]     busy_count;

    modport master (
        output rs1_addr, rs2_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, flush,
        input  rs1_data, rs2_data, rs1_busy, rs2_busy, rsv_ok, busy_count
    );

    modport slave (
        input  rs1_addr, rs2_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, flush,
        output rs1_data, rs2_data, rs1_busy, rs2_busy, rsv_ok, busy_count
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// 2-read/1-write register file with per-register busy bits: long-latency units reserve a
// destination, the matching writeback releases it, and a flush drops every reservation.
module regfile_scoreboard #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    regfile_scoreboard_if.slave  bus
);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [XLEN-1:0]  regs_d [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [AW:0]      busy_count_q;
    logic [AW:0]      busy_count_d;

    logic             wr_fire_s;
    logic             byp1_s;
    logic             byp2_s;
    logic             rsv_release_s;
    logic             rsv_ok_s;
    logic [XLEN-1:0]  rs1_data_s;
    logic [XLEN-1:0]  rs2_data_s;
    logic             rs1_busy_s;
    logic             rs2_busy_s;

    function automatic logic is_zero_addr(input logic [AW-1:0] addr);
        return (ZERO_REG != 0) && (addr == '0);
    endfunction

    // Sized so that an all-busy vector (NREGS = 2**AW) still fits without wrapping.
    function automatic logic [AW:0] popcount(input logic [NREGS-1:0] vec);
        logic [AW:0] cnt;
        cnt = '0;
        for (int i = 0; i < NREGS; i++) begin
            cnt = cnt + {{AW{1'b0}}, vec[i]};
        end
        return cnt;
    endfunction

    // Write qualification, bypass hits and the reservation handshake.
    always_comb begin
        wr_fire_s     = bus.wr_en && !is_zero_addr(bus.wr_addr);
        byp1_s        = (BYPASS != 0) && wr_fire_s && (bus.wr_addr == bus.rs1_addr);
        byp2_s        = (BYPASS != 0) && wr_fire_s && (bus.wr_addr == bus.rs2_addr);
        // A writeback landing on the same register frees it in time for a new owner.
        rsv_release_s = bus.wr_en && (bus.wr_addr == bus.rsv_addr);
        rsv_ok_s      = bus.rsv_en && !bus.flush && (!busy_q[bus.rsv_addr] || rsv_release_s);
    end

    // Read port 1: zero register, then same-cycle forwarding, then stored state.
    always_comb begin
        rs1_data_s = regs_q[bus.rs1_addr];
        rs1_busy_s = busy_q[bus.rs1_addr];
        if (is_zero_addr(bus.rs1_addr)) begin
            rs1_data_s = '0;
            rs1_busy_s = 1'b0;
        end else if (byp1_s) begin
            rs1_data_s = bus.wr_data;
            rs1_busy_s = 1'b0;
        end else begin
            rs1_data_s = regs_q[bus.rs1_addr];
            rs1_busy_s = busy_q[bus.rs1_addr];
        end
    end

    // Read port 2: same priority as port 1.
    always_comb begin
        rs2_data_s = regs_q[bus.rs2_addr];
        rs2_busy_s = busy_q[bus.rs2_addr];
        if (is_zero_addr(bus.rs2_addr)) begin
            rs2_data_s = '0;
            rs2_busy_s = 1'b0;
        end else if (byp2_s) begin
            rs2_data_s = bus.wr_data;
            rs2_busy_s = 1'b0;
        end else begin
            rs2_data_s = regs_q[bus.rs2_addr];
            rs2_busy_s = busy_q[bus.rs2_addr];
        end
    end

    // Next register contents and busy vector; reservation is applied after the release
    // so a same-cycle write + reserve leaves the register owned by the new requester.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (wr_fire_s) begin
            regs_d[bus.wr_addr] = bus.wr_data;
            busy_d[bus.wr_addr] = 1'b0;
        end else begin
            busy_d = busy_q;
        end
        if (rsv_ok_s && !is_zero_addr(bus.rsv_addr)) begin
            busy_d[bus.rsv_addr] = 1'b1;
        end else begin
            busy_d = busy_d;
        end
        if (bus.flush) begin
            busy_d = '0;
        end else begin
            busy_d = busy_d;
        end
        busy_count_d = popcount(busy_d);
    end

    // State registers; reset drops all data and every outstanding reservation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            busy_q       <= '0;
            busy_count_q <= '0;
        end else begin
            regs_q       <= regs_d;
            busy_q       <= busy_d;
            busy_count_q <= busy_count_d;
        end
    end

    assign bus.rs1_data   = rs1_data_s;
    assign bus.rs2_data   = rs2_data_s;
    assign bus.rs1_busy   = rs1_busy_s;
    assign bus.rs2_busy   = rs2_busy_s;
    assign bus.rsv_ok     = rsv_ok_s;
    assign bus.busy_count = busy_count_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench for regfile_scoreboard: expectations are queued as stimulus is driven
// and popped against the DUT outputs a little after the inputs settle.
module tb_regfile_scoreboard;

    localparam int K_D1 = 0;
    localparam int K_D2 = 1;
    localparam int K_B1 = 2;
    localparam int K_B2 = 3;
    localparam int K_OK = 4;
    localparam int K_CNT = 5;

    typedef struct {
        string       tag;
        int          kind;
        logic [63:0] val;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    exp_t sb_q[$];

    logic [31:0] mregs [32];
    logic        mbusy [32];

    regfile_scoreboard_if #(.XLEN(32), .AW(5)) bus ();

    regfile_scoreboard #(
        .XLEN(32), .NREGS(32), .AW(5), .ZERO_REG(1), .BYPASS(1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input int kind, input logic [63:0] val);
        exp_t e;
        e.tag  = tag;
        e.kind = kind;
        e.val  = val;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        exp_t        e;
        logic [63:0] obs;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            case (e.kind)
                K_D1:    obs = {32'd0, bus.rs1_data};
                K_D2:    obs = {32'd0, bus.rs2_data};
                K_B1:    obs = {63'd0, bus.rs1_busy};
                K_B2:    obs = {63'd0, bus.rs2_busy};
                K_OK:    obs = {63'd0, bus.rsv_ok};
                K_CNT:   obs = {58'd0, bus.busy_count};
                default: obs = '1;
            endcase
            check_eq(e.tag, obs, e.val);
        end
    endtask

    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic re, input logic [4:0] ra, input logic fl,
                         input logic [4:0] a1, input logic [4:0] a2);
        bus.wr_en    = we;
        bus.wr_addr  = wa;
        bus.wr_data  = wd;
        bus.rsv_en   = re;
        bus.rsv_addr = ra;
        bus.flush    = fl;
        bus.rs1_addr = a1;
        bus.rs2_addr = a2;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle_and_check();
        #1;
        drain();
    endtask

    initial begin
        logic        we, re, fl, ok;
        logic [4:0]  wa, ra, a1, a2;
        logic [31:0] wd;
        int          cnt;

        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
        tick();

        // 1. reset: every address reads zero / not busy
        for (int i = 0; i < 32; i++) begin
            bus.rs1_addr = 5'(i);
            bus.rs2_addr = 5'(31 - i);
            expect_out("rst_d1", K_D1, 64'd0);
            expect_out("rst_d2", K_D2, 64'd0);
            expect_out("rst_b1", K_B1, 64'd0);
            expect_out("rst_b2", K_B2, 64'd0);
            expect_out("rst_cnt", K_CNT, 64'd0);
            settle_and_check();
        end
        rst_n = 1'b1;
        tick();

        // 2. write reg5 with same-cycle bypass, then stored value
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 5'd5, 5'd5);
        expect_out("byp_d1", K_D1, 64'hDEADBEEF);
        expect_out("byp_d2", K_D2, 64'hDEADBEEF);
        expect_out("byp_b1", K_B1, 64'd0);
        settle_and_check();
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd5, 5'd0);
        expect_out("st_d1", K_D1, 64'hDEADBEEF);
        expect_out("st_d2_zero", K_D2, 64'd0);
        settle_and_check();
        tick();

        // 3. zero register ignores write and reservation
        drive(1'b1, 5'd0, 32'h1234, 1'b1, 5'd0, 1'b0, 5'd0, 5'd0);
        expect_out("z_d1", K_D1, 64'd0);
        expect_out("z_b1", K_B1, 64'd0);
        expect_out("z_ok", K_OK, 64'd1);
        settle_and_check();
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
        expect_out("z_d1_after", K_D1, 64'd0);
        expect_out("z_b1_after", K_B1, 64'd0);
        expect_out("z_cnt", K_CNT, 64'd0);
        settle_and_check();
        tick();

        // 4. reserve reg7, refused re-reserve, release by write
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 1'b0, 5'd0, 5'd7);
        expect_out("r7_ok", K_OK, 64'd1);
        expect_out("r7_b2_same", K_B2, 64'd0);
        settle_and_check();
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 1'b0, 5'd0, 5'd7);
        expect_out("r7_again_ok", K_OK, 64'd0);
        expect_out("r7_b2", K_B2, 64'd1);
        expect_out("r7_cnt", K_CNT, 64'd1);
        settle_and_check();
        tick();
        drive(1'b1, 5'd7, 32'h55, 1'b0, 5'd0, 1'b0, 5'd7, 5'd7);
        expect_out("w7_d1", K_D1, 64'h55);
        expect_out("w7_b1_byp", K_B1, 64'd0);
        expect_out("w7_cnt_hold", K_CNT, 64'd1);
        settle_and_check();
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd7, 5'd7);
        expect_out("w7_d1_st", K_D1, 64'h55);
        expect_out("w7_b2_st", K_B2, 64'd0);
        expect_out("w7_cnt", K_CNT, 64'd0);
        settle_and_check();
        tick();

        // release and re-reserve of a busy register in the same cycle
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 1'b0, 5'd0, 5'd0);
        expect_out("rr_first_ok", K_OK, 64'd1);
        settle_and_check();
        tick();
        drive(1'b1, 5'd7, 32'h77, 1'b1, 5'd7, 1'b0, 5'd7, 5'd0);
        expect_out("rr_ok", K_OK, 64'd1);
        expect_out("rr_d1", K_D1, 64'h77);
        settle_and_check();
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd7, 5'd0);
        expect_out("rr_b1", K_B1, 64'd1);
        expect_out("rr_cnt", K_CNT, 64'd1);
        settle_and_check();
        tick();
        drive(1'b1, 5'd7, 32'h78, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
        settle_and_check();
        tick();

        // 5. reserve 3, 4, 9 then flush with a competing reservation and a write
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 1'b0, 5'd0, 5'd0);
        expect_out("f_ok3", K_OK, 64'd1);
        expect_out("f_cnt0", K_CNT, 64'd0);
        settle_and_check();
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 1'b0, 5'd0, 5'd0);
        expect_out("f_cnt1", K_CNT, 64'd1);
        settle_and_check();
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 1'b0, 5'd0, 5'd0);
        expect_out("f_cnt2", K_CNT, 64'd2);
        settle_and_check();
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 1'b0, 5'd3, 5'd9);
        expect_out("f_ok4_busy", K_OK, 64'd0);
        expect_out("f_b1", K_B1, 64'd1);
        expect_out("f_b2", K_B2, 64'd1);
        expect_out("f_cnt3", K_CNT, 64'd3);
        settle_and_check();
        tick();
        drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd10, 1'b1, 5'd3, 5'd0);
        expect_out("fl_ok", K_OK, 64'd0);
        expect_out("fl_d1", K_D1, 64'h33);
        expect_out("fl_cnt_hold", K_CNT, 64'd3);
        settle_and_check();
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd10, 5'd3);
        expect_out("fl_b1", K_B1, 64'd0);
        expect_out("fl_b2", K_B2, 64'd0);
        expect_out("fl_d2", K_D2, 64'h33);
        expect_out("fl_cnt", K_CNT, 64'd0);
        settle_and_check();
        tick();

        // 6. write + reserve reg12 together, then asynchronous reset mid-cycle
        drive(1'b1, 5'd12, 32'hA5, 1'b1, 5'd12, 1'b0, 5'd12, 5'd0);
        expect_out("wr12_ok", K_OK, 64'd1);
        expect_out("wr12_d1", K_D1, 64'hA5);
        expect_out("wr12_b1", K_B1, 64'd0);
        settle_and_check();
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd12, 5'd5);
        expect_out("wr12_d1_st", K_D1, 64'hA5);
        expect_out("wr12_b1_st", K_B1, 64'd1);
        expect_out("wr12_cnt", K_CNT, 64'd1);
        settle_and_check();
        rst_n = 1'b0;
        expect_out("mid_d1", K_D1, 64'd0);
        expect_out("mid_b1", K_B1, 64'd0);
        expect_out("mid_d2", K_D2, 64'd0);
        expect_out("mid_cnt", K_CNT, 64'd0);
        settle_and_check();
        tick();
        rst_n = 1'b1;
        tick();

        // randomized traffic against a behavioural model
        for (int i = 0; i < 32; i++) begin
            mregs[i] = 32'd0;
            mbusy[i] = 1'b0;
        end
        for (int c = 0; c < 120; c++) begin
            we = 1'($urandom_range(0, 1));
            re = 1'($urandom_range(0, 1));
            fl = ($urandom_range(0, 15) == 0);
            wa = 5'($urandom_range(0, 7));
            ra = 5'($urandom_range(0, 7));
            a1 = 5'($urandom_range(0, 7));
            a2 = 5'($urandom_range(0, 7));
            wd = $urandom;
            drive(we, wa, wd, re, ra, fl, a1, a2);

            cnt = 0;
            for (int i = 0; i < 32; i++) cnt += int'(mbusy[i]);
            expect_out("rnd_cnt", K_CNT, 64'(cnt));
            if (a1 == 5'd0) begin
                expect_out("rnd_d1", K_D1, 64'd0);
                expect_out("rnd_b1", K_B1, 64'd0);
            end else if (we && wa == a1) begin
                expect_out("rnd_d1", K_D1, 64'(wd));
                expect_out("rnd_b1", K_B1, 64'd0);
            end else begin
                expect_out("rnd_d1", K_D1, 64'(mregs[a1]));
                expect_out("rnd_b1", K_B1, 64'(mbusy[a1]));
            end
            if (a2 == 5'd0) begin
                expect_out("rnd_d2", K_D2, 64'd0);
                expect_out("rnd_b2", K_B2, 64'd0);
            end else if (we && wa == a2) begin
                expect_out("rnd_d2", K_D2, 64'(wd));
                expect_out("rnd_b2", K_B2, 64'd0);
            end else begin
                expect_out("rnd_d2", K_D2, 64'(mregs[a2]));
                expect_out("rnd_b2", K_B2, 64'(mbusy[a2]));
            end
            ok = re && !fl && (!mbusy[ra] || (we && wa == ra));
            expect_out("rnd_ok", K_OK, 64'(ok));
            settle_and_check();

            if (we && wa != 5'd0) begin
                mregs[wa] = wd;
                mbusy[wa] = 1'b0;
            end
            if (ok && ra != 5'd0) mbusy[ra] = 1'b1;
            if (fl) begin
                for (int i = 0; i < 32; i++) mbusy[i] = 1'b0;
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
